// File: rtl/register_file.sv
// register_file
//   Banked, multi-ported warp register file. Answers each granted operand read
//   one cycle later on the same port, and absorbs masked writebacks. Banks are
//   single-ported: a writeback claims its bank outright, otherwise one read port
//   per bank is granted by a per-bank round-robin pointer.
//
// Ports
//   clk_i, rst_ni            clock, async active-low reset
//   opc_read_req_*_i         per-port read request (valid, warp id, reg index)
//   rf_read_req_ready_o      per-port grant this cycle (combinational)
//   rf_read_rsp_valid_o      per-port response valid, one cycle after grant
//   rf_read_rsp_data_o       per-port response data, held between responses
//   eu_wb_*_i                writeback (valid, warp, reg, thread mask, data)
module register_file #(
  parameter int NumWarps        = 8,
  parameter int WarpWidth       = 8,
  parameter int RegIdxWidth     = 6,
  parameter int RegWidth        = 4,
  parameter int OperandsPerInst = 3,
  parameter int NumBanks        = 2,
  localparam int WidWidth       = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  localparam int D              = RegWidth * WarpWidth
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [OperandsPerInst-1:0]                 opc_read_req_valid_i,
  input  logic [OperandsPerInst-1:0][WidWidth-1:0]   opc_read_req_wid_i,
  input  logic [OperandsPerInst-1:0][RegIdxWidth-1:0] opc_read_req_reg_idx_i,
  output logic [OperandsPerInst-1:0]                 rf_read_req_ready_o,
  output logic [OperandsPerInst-1:0]                 rf_read_rsp_valid_o,
  output logic [OperandsPerInst-1:0][D-1:0]          rf_read_rsp_data_o,
  input  logic                                       eu_wb_valid_i,
  input  logic [WidWidth-1:0]                        eu_wb_wid_i,
  input  logic [RegIdxWidth-1:0]                     eu_wb_reg_idx_i,
  input  logic [WarpWidth-1:0]                       eu_wb_act_mask_i,
  input  logic [D-1:0]                               eu_wb_data_i
);

  localparam int BankBits = $clog2(NumBanks);
  localparam int BankW    = (NumBanks > 1) ? BankBits : 1;
  localparam int RowW     = WidWidth + RegIdxWidth - BankBits;
  localparam int Rows     = 2 ** RowW;
  localparam int PtrW     = (OperandsPerInst > 1) ? $clog2(OperandsPerInst) : 1;

  // Skewed mapping: adding the warp id spreads the same register of
  // neighbouring warps across banks. NumBanks is a power of two, so the
  // truncated sum is the modulo.
  function automatic logic [BankW-1:0] bank_of(input logic [WidWidth-1:0] wid,
                                               input logic [RegIdxWidth-1:0] idx);
    logic [BankW-1:0] s;
    s = BankW'(idx) + BankW'(wid);
    return (NumBanks == 1) ? '0 : s;
  endfunction

  function automatic logic [RowW-1:0] row_of(input logic [WidWidth-1:0] wid,
                                             input logic [RegIdxWidth-1:0] idx);
    logic [WidWidth+RegIdxWidth-1:0] cat;
    cat = {wid, idx};
    return RowW'(cat >> BankBits);
  endfunction

  logic [D-1:0] mem [NumBanks][Rows];

  logic [OperandsPerInst-1:0][BankW-1:0] rd_bank;
  logic [OperandsPerInst-1:0][RowW-1:0]  rd_row;
  logic [BankW-1:0]                      wb_bank;
  logic [RowW-1:0]                       wb_row;

  logic [NumBanks-1:0][PtrW-1:0]         rr_ptr, rr_nxt;
  logic [OperandsPerInst-1:0]            gnt;
  logic [OperandsPerInst-1:0]            rsp_vld;
  logic [OperandsPerInst-1:0][D-1:0]     rsp_data;

  for (genvar i = 0; i < OperandsPerInst; i++) begin : g_port
    assign rd_bank[i] = bank_of(opc_read_req_wid_i[i], opc_read_req_reg_idx_i[i]);
    assign rd_row[i]  = row_of(opc_read_req_wid_i[i], opc_read_req_reg_idx_i[i]);
  end

  assign wb_bank = bank_of(eu_wb_wid_i, eu_wb_reg_idx_i);
  assign wb_row  = row_of(eu_wb_wid_i, eu_wb_reg_idx_i);

  // Per-bank arbitration: writeback wins the bank; otherwise the first
  // requesting port at or after rr_ptr (wrapping) is granted.
  always_comb begin
    logic found;
    int   p;
    gnt    = '0;
    rr_nxt = rr_ptr;
    found  = 1'b0;
    p      = 0;
    for (int b = 0; b < NumBanks; b++) begin
      found = 1'b0;
      if (!(eu_wb_valid_i && wb_bank == BankW'(b))) begin
        for (int k = 0; k < OperandsPerInst; k++) begin
          p = (int'(rr_ptr[b]) + k) % OperandsPerInst;
          if (!found && opc_read_req_valid_i[p] && rd_bank[p] == BankW'(b)) begin
            gnt[p]    = 1'b1;
            found     = 1'b1;
            rr_nxt[b] = PtrW'((p + 1) % OperandsPerInst);
          end
        end
      end
    end
  end

  // Grants are masked during reset so no handshake can complete while the
  // response path is being held clear.
  assign rf_read_req_ready_o = gnt & {OperandsPerInst{rst_ni}};
  assign rf_read_rsp_valid_o = rsp_vld;
  assign rf_read_rsp_data_o  = rsp_data;

  // Read pipeline and arbitration state. A read and a write never share a
  // bank in one cycle, so the read sees pre-edge contents without hazard.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld  <= '0;
      rsp_data <= '0;
      rr_ptr   <= '0;
    end else begin
      rsp_vld <= gnt;
      rr_ptr  <= rr_nxt;
      for (int i = 0; i < OperandsPerInst; i++)
        if (gnt[i]) rsp_data[i] <= mem[rd_bank[i]][rd_row[i]];
    end
  end

  // Storage with per-thread write enables.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NumBanks; b++)
        for (int r = 0; r < Rows; r++)
          mem[b][r] <= '0;
    end else if (eu_wb_valid_i) begin
      for (int t = 0; t < WarpWidth; t++)
        if (eu_wb_act_mask_i[t])
          mem[wb_bank][wb_row][t*RegWidth +: RegWidth] <= eu_wb_data_i[t*RegWidth +: RegWidth];
    end
  end

endmodule
